multiaddr_expand: RTL and testbench
===================================

# multiaddr_expand

Sequential expander that turns a multi-address in {addr, mask} form into the individual concrete addresses it covers, one per output handshake. Masked bits are don't-cares, so a set with K masked bits expands to 2^K addresses. The block sits downstream of the multi-address decoder, on the unicast-only side of a multicast path. There it serialises a decoded {addr_o, mask_o} subset into plain addresses for slaves or memories that cannot accept a mask.

## Interface
Parameters:
- AddrWidth, default 32: width of addresses and masks.
- addr_t, default logic [AddrWidth-1:0]: address type.
- MaxSetBits, default 8: maximum number of masked bits expanded. Sets with more masked bits are rejected (see error handling).
- IdxWidth, default MaxSetBits (dependent, do not override): width of idx_o.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_ni, input, 1: reset, asynchronous, active-low.
- valid_i, input, 1: request valid.
- ready_o, output, 1: request accepted when valid_i && ready_o.
- addr_i, input, addr_t: request base address.
- mask_i, input, addr_t: request mask (1 = don't-care bit).
- valid_o, output, 1: output beat valid.
- ready_i, input, 1: output beat consumed when valid_o && ready_i.
- addr_o, output, addr_t: concrete address of the current beat.
- idx_o, output, IdxWidth: beat number within the current request, starting at 0.
- last_o, output, 1: current beat is the final beat of the request.
- error_o, output, 1: request rejected (too many masked bits). Qualified by valid_o.

## Operation
- FSM states: IDLE, EXPAND.
- IDLE:
  - ready_o=1, valid_o=0.
  - On a request handshake, register base_q = addr_i & ~mask_i, mask_q = mask_i, offset_q = 0 and idx_q = 0, then go to EXPAND.
- Acceptance check: if popcount(mask_i) > MaxSetBits, register mask_q = 0 and err_q = 1. The request then produces exactly one beat with addr_o = addr_i & ~mask_i, error_o=1, last_o=1.
- EXPAND:
  - ready_o=0, valid_o=1.
  - addr_o = base_q | offset_q.
  - idx_o = idx_q.
  - last_o = (offset_q == mask_q).
  - error_o = err_q.
- On an output handshake that is not the last beat:
  - offset_q <= ((offset_q | ~mask_q) + 1) & mask_q. This masked increment yields ascending order over the masked bits only. The carry out of the MSB is discarded.
  - idx_q <= idx_q + 1.
- On an output handshake of the last beat: go to IDLE and clear err_q.
- mask_i = 0 produces a single beat with addr_o = addr_i, idx_o=0, last_o=1.
- Beat count for a legal request is exactly 2^popcount(mask_i). idx_o never wraps, because the count is at most 2^MaxSetBits.
- No overlap between requests: the next request cannot be accepted in the cycle of the last output handshake.

## Timing
- Reset values (asserted asynchronously, held while rst_ni=0):
  - state=IDLE, so ready_o=1.
  - valid_o=0.
  - addr_o=0, idx_o=0, last_o=0, error_o=0, since all internal registers are 0.
- All outputs are driven from registers only. There is no combinational path from valid_i/addr_i/mask_i/ready_i to any output.
- Latency: request accepted at cycle N gives the first beat valid at N+1.
- Throughput: one beat per cycle while ready_i=1. A request with B beats occupies B cycles of EXPAND plus at least one IDLE cycle. Peak request rate is one per B+1 cycles.
- Stability: while valid_o && !ready_i, addr_o, idx_o, last_o and error_o hold unchanged. valid_o never deasserts without a handshake.
- Reset mid-expansion: the remaining beats are dropped. After rst_ni rises the block is in IDLE, and the next request starts at idx 0.
- valid_i and addr_i/mask_i are sampled only in IDLE. Changes to them while in EXPAND are ignored.

## Test plan
- Mask zero: addr_i=0x0000_1000, mask_i=0 -> one beat at cycle N+1 with addr_o=0x1000, idx_o=0, last_o=1, error_o=0. ready_o=1 again at N+2.
- Sparse mask: addr_i=0x1234, mask_i=0x105 -> 8 beats with addr_o = 0x1230, 0x1231, 0x1234, 0x1235, 0x1330, 0x1331, 0x1334, 0x1335. idx_o runs 0..7 and last_o is set only on the 8th beat.
- Backpressure: same request as the sparse-mask case, with ready_i=0 for 3 cycles on beat 2 -> addr_o=0x1234 and idx_o=2 held stable. No beat is skipped or duplicated, and the total is still 8.
- Rejection: MaxSetBits=4, addr_i=0x40, mask_i=0x1F (5 bits) -> single beat addr_o=0x40, error_o=1, last_o=1. The next legal request has error_o=0.
- Reset mid-stream: mask_i=0xF, rst_ni pulsed low after 3 beats -> valid_o=0 and ready_o=1 immediately. A new request addr_i=0x200, mask_i=0x1 yields 0x200 then 0x201 with idx 0 and 1.
- Back-to-back: second request held on valid_i during the first expansion -> ready_o=0 until the cycle after the first request's last handshake. The second request is accepted then, with no lost or merged beats.

Source files
------------

// File: rtl/multiaddr_expand_if.sv
// ============================================================================
// Module      : multiaddr_expand_if
// Description : Request/beat handshake bundle for the multi-address expander.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface multiaddr_expand_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdxWidth  = 8
) ();

    // Request side: one {addr, mask} multi-address
    logic                 valid_i;
    logic                 ready_o;
    logic [AddrWidth-1:0] addr_i;
    logic [AddrWidth-1:0] mask_i;

    // Beat side: one concrete address per handshake
    logic                 valid_o;
    logic                 ready_i;
    logic [AddrWidth-1:0] addr_o;
    logic [IdxWidth-1:0]  idx_o;
    logic                 last_o;
    logic                 error_o;

    modport master (
        output valid_i, addr_i, mask_i, ready_i,
        input  ready_o, valid_o, addr_o, idx_o, last_o, error_o
    );

    modport slave (
        input  valid_i, addr_i, mask_i, ready_i,
        output ready_o, valid_o, addr_o, idx_o, last_o, error_o
    );

endinterface

`default_nettype wire

// File: rtl/multiaddr_expand.sv
// ============================================================================
// Module      : multiaddr_expand
// Description : Serialises an {addr, mask} multi-address into its 2^K concrete
//               addresses, one per output handshake, in ascending order.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multiaddr_expand #(
    parameter int unsigned AddrWidth  = 32,
    parameter type         addr_t     = logic [AddrWidth-1:0],
    parameter int unsigned MaxSetBits = 8,
    parameter int unsigned IdxWidth   = MaxSetBits
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    multiaddr_expand_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    addr_t               base_q, base_d;
    addr_t               mask_q, mask_d;
    addr_t               offset_q, offset_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic                err_q, err_d;

    logic [31:0]         set_bits;
    logic                too_many;
    logic                is_last;

    always_comb begin
        set_bits = '0;
        for (int i = 0; i < int'(AddrWidth); i++) begin
            set_bits = set_bits + 32'(bus.mask_i[i]);
        end
    end

    assign too_many = (set_bits > MaxSetBits);
    assign is_last  = (offset_q == mask_q);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        mask_d   = mask_q;
        offset_d = offset_q;
        idx_d    = idx_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    base_d   = bus.addr_i & ~bus.mask_i;
                    offset_d = '0;
                    idx_d    = '0;
                    state_d  = EXPAND;
                    // A rejected set collapses to a single error beat
                    if (too_many) begin
                        mask_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        mask_d = bus.mask_i;
                        err_d  = 1'b0;
                    end
                end
            end
            EXPAND: begin
                if (bus.ready_i) begin
                    if (is_last) begin
                        state_d = IDLE;
                        err_d   = 1'b0;
                    end else begin
                        // Filling unmasked bits with 1s makes the carry ripple
                        // straight across them to the next masked bit
                        offset_d = ((offset_q | ~mask_q) + addr_t'(1)) & mask_q;
                        idx_d    = idx_q + IdxWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            base_q   <= '0;
            mask_q   <= '0;
            offset_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            mask_q   <= mask_d;
            offset_q <= offset_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == EXPAND);
    assign bus.addr_o  = base_q | offset_q;
    assign bus.idx_o   = idx_q;
    assign bus.last_o  = (state_q == EXPAND) && is_last;
    assign bus.error_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_multiaddr_expand.sv
// ============================================================================
// Module      : tb_multiaddr_expand
// Description : Directed self-checking bench for multiaddr_expand.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_multiaddr_expand;

    localparam int unsigned AW  = 32;
    localparam int unsigned MSB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_a [16];

    always #5 clk = ~clk;

    multiaddr_expand_if #(.AddrWidth(AW), .IdxWidth(MSB)) bus ();

    multiaddr_expand #(
        .AddrWidth  (AW),
        .MaxSetBits (MSB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] m);
        int w = 0;
        bus.valid_i = 1'b1;
        bus.addr_i  = a;
        bus.mask_i  = m;
        while (!bus.ready_o && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready", 32'(bus.ready_o), 32'd1);
        tick();
        bus.valid_i = 1'b0;
        bus.addr_i  = 32'hDEAD_BEEF;
        bus.mask_i  = 32'hFFFF_FFFF;
    endtask

    // Consume n beats checking against exp_a; optional stall on one beat
    task automatic run_beats(input int n, input bit err, input int stall_at,
                             input int stall_n, input bit chk_busy);
        for (int b = 0; b < n; b++) begin
            chk($sformatf("valid_b%0d", b), 32'(bus.valid_o), 32'd1);
            chk($sformatf("addr_b%0d", b), bus.addr_o, exp_a[b]);
            chk($sformatf("idx_b%0d", b), 32'(bus.idx_o), 32'(b));
            chk($sformatf("last_b%0d", b), 32'(bus.last_o), 32'(b == n - 1));
            chk($sformatf("err_b%0d", b), 32'(bus.error_o), 32'(err));
            if (chk_busy) chk($sformatf("busy_b%0d", b), 32'(bus.ready_o), 32'd0);
            if (b == stall_at) begin
                bus.ready_i = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk($sformatf("hold_valid_s%0d", s), 32'(bus.valid_o), 32'd1);
                    chk($sformatf("hold_addr_s%0d", s), bus.addr_o, exp_a[b]);
                    chk($sformatf("hold_idx_s%0d", s), 32'(bus.idx_o), 32'(b));
                end
                bus.ready_i = 1'b1;
            end
            tick();
        end
        chk("idle_valid", 32'(bus.valid_o), 32'd0);
        chk("idle_ready", 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.addr_i  = '0;
        bus.mask_i  = '0;
        bus.ready_i = 1'b1;

        // Reset state
        #2;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_addr",  bus.addr_o, 32'd0);
        chk("rst_idx",   32'(bus.idx_o), 32'd0);
        chk("rst_last",  32'(bus.last_o), 32'd0);
        chk("rst_err",   32'(bus.error_o), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Mask zero: single beat, ready again right after
        exp_a[0] = 32'h0000_1000;
        send(32'h0000_1000, 32'h0);
        run_beats(1, 1'b0, -1, 0, 1'b0);

        // Sparse mask
        exp_a[0] = 32'h1230; exp_a[1] = 32'h1231; exp_a[2] = 32'h1234; exp_a[3] = 32'h1235;
        exp_a[4] = 32'h1330; exp_a[5] = 32'h1331; exp_a[6] = 32'h1334; exp_a[7] = 32'h1335;
        send(32'h1234, 32'h105);
        run_beats(8, 1'b0, -1, 0, 1'b0);

        // Backpressure on beat 2 for 3 cycles
        send(32'h1234, 32'h105);
        run_beats(8, 1'b0, 2, 3, 1'b0);

        // Rejection: 5 masked bits with MaxSetBits=4
        exp_a[0] = 32'h40;
        send(32'h40, 32'h1F);
        run_beats(1, 1'b1, -1, 0, 1'b0);
        exp_a[0] = 32'h44; exp_a[1] = 32'h46;
        send(32'h44, 32'h2);
        run_beats(2, 1'b0, -1, 0, 1'b0);

        // Reset mid-stream after 3 beats
        for (int i = 0; i < 16; i++) exp_a[i] = 32'h300 + 32'(i);
        send(32'h300, 32'hF);
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("pre_rst_addr_b%0d", b), bus.addr_o, exp_a[b]);
            tick();
        end
        chk("pre_rst_idx", 32'(bus.idx_o), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready_o), 32'd1);
        chk("mid_rst_idx",   32'(bus.idx_o), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        exp_a[0] = 32'h200; exp_a[1] = 32'h201;
        send(32'h200, 32'h1);
        run_beats(2, 1'b0, -1, 0, 1'b0);

        // Back-to-back: second request held during the first expansion
        bus.valid_i = 1'b1;
        bus.addr_i  = 32'h500;
        bus.mask_i  = 32'h3;
        tick();
        bus.addr_i  = 32'h600;
        bus.mask_i  = 32'h10;
        exp_a[0] = 32'h500; exp_a[1] = 32'h501; exp_a[2] = 32'h502; exp_a[3] = 32'h503;
        run_beats(4, 1'b0, -1, 0, 1'b1);
        tick();
        bus.valid_i = 1'b0;
        exp_a[0] = 32'h600; exp_a[1] = 32'h610;
        run_beats(2, 1'b0, -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
